// File: rtl/lc3_wb_pkg.sv
// Shared definitions for the LC3 memory-access / writeback stage:
// opcodes, writeback-source and FSM enums, PSR reset value, NZP helper.
package lc3_wb_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  localparam logic [2:0] PSR_RESET = 3'b010;

  typedef enum logic [1:0] {
    WC_ALU  = 2'd0,
    WC_MEM  = 2'd1,
    WC_PC   = 2'd2,
    WC_NONE = 2'd3
  } wctl_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_IND  = 2'd1,
    S_RD_DATA = 2'd2
  } state_e;

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == '0)   return 3'b010;
    else                return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_regfile_8x16.sv
// 8x16 register file: two async read ports, one sync write port, sync reset.
// Define LC3_WB_BYPASS_EN for write-through on the read ports.
module lc3_regfile_8x16
  #(parameter logic [15:0] RESET_VAL = 16'h0000)
  (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  raddr1_i,
  input  logic [2:0]  raddr2_i,
  output logic [15:0] rdata1_o,
  output logic [15:0] rdata2_o
);

  logic [15:0] mem_q [8];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 8; i++) mem_q[i[2:0]] <= RESET_VAL;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef LC3_WB_BYPASS_EN
  assign rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
`else
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
`endif

endmodule

// File: rtl/lc3_memaccess_writeback.sv
// LC3 memory-access and writeback stage: loads/stores (incl. indirect), regfile, PSR, branch resolve.
// Optional macro LC3_WB_BYPASS_EN enables write-through on VSR1/VSR2.
module lc3_memaccess_writeback
  import lc3_wb_pkg::*;
  #(
  parameter logic [15:0] REG_RESET_VAL = 16'h0000,
  parameter logic [2:0]  PSR_RESET_VAL = PSR_RESET
  )
  (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [15:0] aluout,
  input  logic [15:0] pcout,
  input  logic [1:0]  W_Control_out,
  input  logic        Mem_Control_out,
  input  logic [2:0]  NZP,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic [2:0]  dr,
  input  logic [15:0] M_Data,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr,
  output logic        br_taken,
  output logic        busy,
  output logic        wb_done,
  output logic        err_overrun
);

  state_e      state_q, state_d;
  logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  psr_q, psr_d;
  logic        br_q, br_d, done_q, done_d, err_q, err_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] stdata_q, stdata_d;
  logic        sti_q, sti_d;

  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  wctl_e      wctl;
  logic [3:0] opcode;
  logic       unused_ir;

  assign wctl      = wctl_e'(W_Control_out);
  assign opcode    = IR_Exec[15:12];
  assign unused_ir = ^IR_Exec[11:0];

  lc3_regfile_8x16 #(.RESET_VAL(REG_RESET_VAL)) u_regfile (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (VSR1),
    .rdata2_o (VSR2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      psr_q    <= PSR_RESET_VAL;
      br_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dr_q     <= '0;
      stdata_q <= '0;
      sti_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      psr_q    <= psr_d;
      br_q     <= br_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dr_q     <= dr_d;
      stdata_q <= stdata_d;
      sti_q    <= sti_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable_execute) begin
          if (wctl == WC_MEM)
            state_d = Mem_Control_out ? S_RD_IND : S_RD_DATA;
          else if (wctl == WC_NONE && opcode == OP_STI)
            state_d = S_RD_IND;
        end
      end
      S_RD_IND:  if (mem_rvalid) state_d = sti_q ? S_IDLE : S_RD_DATA;
      S_RD_DATA: if (mem_rvalid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pulse outputs default low so each request is exactly one cycle wide.
  always_comb begin
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    br_d     = 1'b0;
    done_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dr_d     = dr_q;
    stdata_d = stdata_q;
    sti_d    = sti_q;
    err_d    = err_q | (enable_execute && state_q != S_IDLE);
    rf_we    = 1'b0;
    rf_waddr = dr;
    rf_wdata = aluout;
    case (state_q)
      S_IDLE: begin
        if (enable_execute) begin
          case (wctl)
            WC_ALU, WC_PC: begin
              rf_we    = 1'b1;
              rf_wdata = (wctl == WC_PC) ? pcout : aluout;
              done_d   = 1'b1;
            end
            WC_MEM: begin
              rd_en_d = 1'b1;
              addr_d  = aluout;
              dr_d    = dr;
              sti_d   = 1'b0;
            end
            default: begin
              if (opcode == OP_ST || opcode == OP_STR) begin
                wr_en_d = 1'b1;
                addr_d  = aluout;
                wdata_d = M_Data;
                done_d  = 1'b1;
              end else if (opcode == OP_STI) begin
                rd_en_d  = 1'b1;
                addr_d   = aluout;
                stdata_d = M_Data;
                sti_d    = 1'b1;
              end else begin
                done_d = 1'b1;
                if (opcode == OP_BR) br_d = |(NZP & psr_q);
              end
            end
          endcase
        end
      end
      S_RD_IND: begin
        if (mem_rvalid) begin
          addr_d = mem_rdata;
          if (sti_q) begin
            wr_en_d = 1'b1;
            wdata_d = stdata_q;
            done_d  = 1'b1;
          end else begin
            rd_en_d = 1'b1;
          end
        end
      end
      S_RD_DATA: begin
        if (mem_rvalid) begin
          rf_we    = 1'b1;
          rf_waddr = dr_q;
          rf_wdata = mem_rdata;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
    psr_d = rf_we ? nzp_of(rf_wdata) : psr_q;
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign psr         = psr_q;
  assign br_taken    = br_q;
  assign busy        = (state_q != S_IDLE);
  assign wb_done     = done_q;
  assign err_overrun = err_q;

endmodule
